// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word-aligned reads to
// instruction memory under a credit limit, and buffers in-order responses
// with their PCs in a small prefetch FIFO for decode. Responses to requests
// issued before a redirect are counted and discarded.
module instruction_fetch_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-3:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc
);

  localparam int unsigned      CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned      PW         = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]      DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  // Architectural state
  logic [WIDTH-3:0] r_fetch_word;
  logic [WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_drop;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

  // Derived control
  logic [CW:0]      w_inflight;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_dropping;
  logic             w_push;
  logic             w_pop;
  logic             w_inst_valid;
  logic [WIDTH-1:0] w_redirect_pc;
  logic [CW-1:0]    w_out_after_resp;

  assign w_inflight       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid      = !rst && !redirect_valid && (w_inflight < DEPTH_C);
  assign w_req_fire       = w_req_valid && imem_req_ready;
  assign w_dropping       = (r_drop != '0);
  assign w_inst_valid     = (r_count != '0);
  assign w_push           = imem_resp_valid && !w_dropping && !redirect_valid;
  assign w_pop            = w_inst_valid && inst_ready && !redirect_valid;
  assign w_redirect_pc    = redirect_pc & ALIGN_MASK;
  // A response arriving with the redirect is itself stale, so it is retired
  // here and excluded from the number of responses left to discard.
  assign w_out_after_resp = r_outstanding - CW'(imem_resp_valid);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_word;
  assign inst_valid     = w_inst_valid;
  assign inst_data      = w_inst_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign inst_pc        = w_inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;

  // Fetch/response PCs, in-flight and discard counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_word  <= RESET_PC_A[WIDTH-1:2];
      r_resp_pc     <= RESET_PC_A;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      r_fetch_word  <= w_redirect_pc[WIDTH-1:2];
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= w_out_after_resp;
      r_drop        <= w_out_after_resp;
    end else begin
      if (w_req_fire) begin
        r_fetch_word <= r_fetch_word + 1'b1;
      end
      if (imem_resp_valid) begin
        if (w_dropping) begin
          r_drop <= r_drop - 1'b1;
        end else begin
          r_resp_pc <= r_resp_pc + PC_STEP;
        end
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
    end
  end

  // Prefetch FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Prefetch FIFO storage; contents are masked by occupancy so need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a behavioural memory
// responder plus an epoch-based model of which instructions decode must see.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [29:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  instruction_fetch_unit #(
    .WIDTH      (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory requests in flight, tagged with the path epoch they belong to
  typedef struct {
    logic [29:0] waddr;
    int unsigned ep;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];

  int unsigned cyc, epoch, buffered, last_due, n_hs;
  int unsigned p_ird, p_mrdy, p_redir, lat_min, lat_max;
  int unsigned n_checks, n_errors;
  logic [31:0] exp_pc, exp_req, force_tgt;
  bit          force_redir;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return {wa, 2'b00} ^ 32'hC3A5_5A3C ^ {wa[22:0], 9'h000};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic step();
    logic        redir, rv, hs, exp_valid;
    logic [31:0] tgt;
    mreq_t       r;
    int unsigned due;
    inst_ready     = ($urandom_range(99) < p_ird);
    imem_req_ready = ($urandom_range(99) < p_mrdy);
    redir          = force_redir || ($urandom_range(999) < p_redir);
    tgt            = force_redir ? force_tgt : $urandom();
    force_redir    = 1'b0;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rv             = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_word(mq[0].waddr) : $urandom();

    @(negedge clk);
    exp_valid = !redir && ((mq.size() + buffered) < DEPTH);
    check_eq("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_valid});
    if (exp_valid) check_eq("req_addr", {34'd0, imem_req_addr}, {34'd0, exp_req[31:2]});
    check_eq("inst_valid", {63'd0, inst_valid}, {63'd0, buffered != 0});
    if (buffered != 0) begin
      check_eq("inst_pc", {32'd0, inst_pc}, {32'd0, exp_pc});
      check_eq("inst_data", {32'd0, inst_data}, {32'd0, mem_word(exp_pc[31:2])});
    end else begin
      check_eq("inst_pc_empty", {32'd0, inst_pc}, 64'd0);
      check_eq("inst_data_empty", {32'd0, inst_data}, 64'd0);
    end

    hs = exp_valid && imem_req_ready;
    r  = '{waddr: '0, ep: 0, due: 0};
    if (rv) r = mq.pop_front();
    if (hs) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{waddr: exp_req[31:2], ep: epoch, due: due});
      n_hs++;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
      exp_pc   = tgt & ~32'd3;
      exp_req  = tgt & ~32'd3;
    end else begin
      if (hs) exp_req += 32'd4;
      if (buffered != 0 && inst_ready) begin
        exp_pc += 32'd4;
        buffered--;
      end
      if (rv && r.ep == epoch) buffered++;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must react before any clock edge
  task automatic apply_reset(input int unsigned hold);
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check_eq("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check_eq("rst_req_addr", {34'd0, imem_req_addr}, {34'd0, RST_PC[31:2]});
    check_eq("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check_eq("rst_inst_data", {32'd0, inst_data}, 64'd0);
    check_eq("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
    mq.delete();
    epoch++;
    buffered = 0;
    exp_pc   = RST_PC & ~32'd3;
    exp_req  = RST_PC & ~32'd3;
    repeat (hold) @(posedge clk);
    #1;
    cyc     += hold;
    last_due = cyc;
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    cyc = 0; epoch = 0; buffered = 0; last_due = 0; n_hs = 0;
    n_checks = 0; n_errors = 0; force_redir = 1'b0; force_tgt = '0;
    exp_pc = RST_PC; exp_req = RST_PC;
    p_ird = 100; p_mrdy = 100; p_redir = 0; lat_min = 1; lat_max = 1;

    // Streaming fetch with a 1-cycle memory
    apply_reset(2);
    repeat (20) step();

    // Decode stalled: credit limits issue to the FIFO depth
    apply_reset(2);
    p_ird = 0; n_hs = 0;
    repeat (20) step();
    check_eq("stall_req_count", {32'd0, n_hs}, 64'd4);
    p_ird = 100;
    repeat (10) step();

    // Memory not ready for 3 cycles: address held at word 5
    apply_reset(2);
    repeat (5) step();
    p_mrdy = 0;
    repeat (3) step();
    check_eq("held_addr", {34'd0, imem_req_addr}, 64'd5);
    p_mrdy = 100;
    repeat (10) step();

    // 3-cycle memory, redirect with responses in flight and one arriving
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() >= 2 && mq[0].due <= cyc) break;
      step();
    end
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    repeat (20) step();

    // Redirect near the top of the address space: PC wraps to 0
    lat_min = 1; lat_max = 1;
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    repeat (10) step();

    // Reset with the FIFO half full, then restart
    apply_reset(2);
    p_ird = 0;
    repeat (3) step();
    apply_reset(2);
    p_ird = 100;
    repeat (10) step();

    // Randomized traffic
    for (int seg = 0; seg < 12; seg++) begin
      p_ird   = $urandom_range(100, 20);
      p_mrdy  = $urandom_range(100, 20);
      p_redir = $urandom_range(60, 0);
      lat_min = $urandom_range(2, 1);
      lat_max = $urandom_range(4, lat_min);
      if (seg == 6) apply_reset(1);
      repeat (300) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
